// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit.
// States, ALU selects, opcodes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Immediate format follows the opcode alone.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    unique case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode from ALUOp and the funct fields.
// Flags funct3 values the ALU cannot execute.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  // Select ALU op; funct decode only when ALUOp asks for it.
  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM.
// Moore decode of the state register; PCWrite gated by Zero.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal,
  output logic       InstrDone
);

  state_t     state, state_n;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       irw, regw, memw, done;
  logic       op_ok, dec_bad, bad_funct;

  // Opcodes this unit knows how to sequence.
  always_comb begin
    op_ok = (op == OP_LW) | (op == OP_SW) | (op == OP_R) |
            (op == OP_I) | (op == OP_JAL) | (op == OP_BEQ);
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Next-state selection.
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_n = S_MEMADR;
          (op == OP_R):   state_n = S_EXECUTER;
          (op == OP_I):   state_n = S_EXECUTEI;
          (op == OP_JAL): state_n = S_JAL;
          (op == OP_BEQ): state_n = S_BEQ;
          default:        state_n = S_FETCH;
        endcase
      end
      S_MEMADR:   state_n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_n = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_n = S_ALUWB;
      default:    state_n = S_FETCH;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = ADR_PC;
    aluop     = ALUOP_ADD;
    irw       = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    done      = 1'b0;
    dec_bad   = 1'b0;
    case (state)
      S_FETCH: begin
        irw       = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        dec_bad = ~op_ok;
        done    = ~op_ok;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = ADR_RESULT;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regw      = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = ADR_RESULT;
        memw   = 1'b1;
        done   = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regw = 1'b1;
        done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl),
    .bad_funct  (bad_funct)
  );

  assign ImmSrc    = imm_sel(op);
  assign IRWrite   = irw & ~reset;
  assign PCWrite   = (pcupdate | (branch & Zero)) & ~reset;
  assign RegWrite  = regw & ~reset;
  assign MemWrite  = memw & ~reset;
  assign Illegal   = (dec_bad | bad_funct) & ~reset;
  assign InstrDone = done & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller.
// Each cycle compares a packed control vector to hand-built constants.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic       Illegal, InstrDone;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Illegal    (Illegal),
    .InstrDone  (InstrDone)
  );

  always #5 clk = ~clk;

  // {IRW,PCW,RegW,MemW,Ill,Done}_SrcA_SrcB_Result_Adr_ALUCtl
  localparam logic [15:0] V_RST  = 16'b000000_00_10_10_0_000;
  localparam logic [15:0] V_F    = 16'b110000_00_10_10_0_000;
  localparam logic [15:0] V_D    = 16'b000000_01_01_00_0_000;
  localparam logic [15:0] V_MA   = 16'b000000_10_01_00_0_000;
  localparam logic [15:0] V_MR   = 16'b000000_00_00_00_1_000;
  localparam logic [15:0] V_MWB  = 16'b001001_00_00_01_0_000;
  localparam logic [15:0] V_MW   = 16'b000101_00_00_00_1_000;
  localparam logic [15:0] V_SUB  = 16'b000000_10_00_00_0_001;
  localparam logic [15:0] V_SLT  = 16'b000000_10_00_00_0_101;
  localparam logic [15:0] V_ADDI = 16'b000000_10_01_00_0_000;
  localparam logic [15:0] V_IILL = 16'b000010_10_01_00_0_000;
  localparam logic [15:0] V_WB   = 16'b001001_00_00_00_0_000;
  localparam logic [15:0] V_BQ1  = 16'b010001_10_00_00_0_001;
  localparam logic [15:0] V_BQ0  = 16'b000001_10_00_00_0_001;
  localparam logic [15:0] V_JAL  = 16'b010000_01_10_00_0_000;
  localparam logic [15:0] V_DILL = 16'b000011_01_01_00_0_000;

  function automatic logic [15:0] outvec();
    outvec = {IRWrite, PCWrite, RegWrite, MemWrite, Illegal, InstrDone,
              ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    #1;
    chk(tag, outvec(), exp);
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    Zero     = 1'b1;
    #1;
    chk("rst_init", outvec(), V_RST);
    step("rst_hold", V_RST);
    reset = 1'b0;
    #1;
    chk("rel_fetch", outvec(), V_F);
    step("lw0_dec", V_D);
    step("lw0_madr", V_MA);
    step("lw0_mrd", V_MR);
    reset = 1'b1;
    #1;
    chk("midrst", outvec(), V_RST);
    step("midrst_hold", V_RST);
    reset = 1'b0;
    #1;
    chk("midrst_rel", outvec(), V_F);

    step("lw_dec", V_D);
    step("lw_madr", V_MA);
    step("lw_mrd", V_MR);
    step("lw_mwb", V_MWB);
    step("lw_fetch", V_F);

    op = 7'b0100011;
    step("sw_dec", V_D);
    chk("sw_imm", {14'd0, ImmSrc}, 16'd1);
    step("sw_madr", V_MA);
    step("sw_mwr", V_MW);
    step("sw_fetch", V_F);

    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step("sub_dec", V_D);
    step("sub_exe", V_SUB);
    step("sub_wb", V_WB);
    step("sub_fetch", V_F);

    funct3 = 3'b010; funct7b5 = 1'b0;
    step("slt_dec", V_D);
    step("slt_exe", V_SLT);
    step("slt_wb", V_WB);
    step("slt_fetch", V_F);

    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step("addi_dec", V_D);
    step("addi_exe", V_ADDI);
    step("addi_wb", V_WB);
    step("addi_fetch", V_F);

    funct3 = 3'b001;
    step("iill_dec", V_D);
    step("iill_exe", V_IILL);
    step("iill_wb", V_WB);
    step("iill_fetch", V_F);

    op = 7'b1100011; Zero = 1'b1;
    step("beq1_dec", V_D);
    chk("beq_imm", {14'd0, ImmSrc}, 16'd2);
    step("beq1_br", V_BQ1);
    step("beq1_fetch", V_F);

    Zero = 1'b0;
    step("beq0_dec", V_D);
    step("beq0_br", V_BQ0);
    step("beq0_fetch", V_F);

    op = 7'b1101111; Zero = 1'b1;
    step("jal_dec", V_D);
    chk("jal_imm_d", {14'd0, ImmSrc}, 16'd3);
    step("jal_jal", V_JAL);
    chk("jal_imm_j", {14'd0, ImmSrc}, 16'd3);
    step("jal_wb", V_WB);
    step("jal_fetch", V_F);

    op = 7'b1111111;
    step("ill_dec", V_DILL);
    step("ill_fetch", V_F);
    step("ill_next", V_DILL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
